imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the single clock of the block.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  the value on inst is valid.
REQ-005 SHALL have port in_ready  output  1  the block accepts inst this cycle.
REQ-006 SHALL have port inst  input  32  RV32I instruction word.
REQ-007 SHALL have port out_valid  output  1  imm/fmt/illegal valid.
REQ-008 SHALL have port out_ready  input  1  the consumer accepts output this cycle.
REQ-009 SHALL have port imm  output  XLEN  sign-extended immediate.
REQ-010 SHALL have port fmt  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
REQ-011 SHALL have port illegal  output  1  the opcode is unrecognised.

Function
REQ-012 SHALL decode inst[6:0] as follows:
- I: 0000011, 0010011, 1100111, 0001111, 1110011.
- S: 0100011.
- B: 1100011.
- U: 0110111, 0010111.
- J: 1101111.
- R: 0110011.
- Any other value: ILL.
REQ-013 SHALL form the immediate per format:
- I = inst[31:20].
- S = {inst[31:25],inst[11:7]}.
- B = {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}.
- U = {inst[31:12],12'b0}.
- J = {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}.
REQ-014 SHALL sign-extend every immediate from inst[31] to XLEN bits.
REQ-015 SHALL output imm=0 for R and ILL, with illegal=1 only for ILL.
REQ-016 SHALL transfer an input when in_valid&&in_ready, and an output when out_valid&&out_ready.
REQ-017 SHALL present a result on imm/fmt/illegal exactly 1 cycle after its input transfer, when the output is free.
REQ-018 SHALL hold imm/fmt/illegal/out_valid stable while out_valid&&!out_ready.
REQ-019 SHALL deliver results in input order, with no loss or duplication.
REQ-020 SHALL support a simultaneous input and output transfer in one cycle, sustaining 1 result per cycle.
REQ-021 SHALL ignore inst when in_valid=0.

Reset
REQ-022 SHALL, while rst=1 at a clk edge, clear out_valid=0, imm=0, fmt=0, illegal=0 and all buffer-valid state.
REQ-023 SHALL, during reset and in the cycle after it, hold in_ready=1 (skid build) or follow REQ-026 (no-skid build).
REQ-024 SHALL, on reset mid-operation, discard any buffered or in-flight result; no output transfer occurs in the reset cycle.

Configuration
REQ-025 SHALL, when IMM_GEN_SKID_EN is defined, use a 2-entry skid buffer:
- in_ready is a register output, equal to !skid_valid.
- A result arriving while the output is stalled goes into the skid entry.
- The skid entry moves to the output on the next out_ready.
- There is no combinational path from out_ready to in_ready.
REQ-026 SHALL, when IMM_GEN_SKID_EN is undefined, use a single output register with in_ready = !out_valid || out_ready (combinational).
REQ-027 SHALL keep identical result values, ordering and 1-cycle latency in both builds.

Verification
REQ-028 SHALL cover immediate decode with out_ready=1, one instruction at a time:
- 0xFFF00093 (addi x1,x0,-1) -> imm=0xFFFFFFFF, fmt=1, illegal=0.
- 0xFE112E23 (sw x1,-4(x2)) -> imm=0xFFFFFFFC, fmt=2.
- 0xFE000CE3 (beq x0,x0,-8) -> imm=0xFFFFFFF8, fmt=3.
REQ-029 SHALL cover U, J, R and illegal decode:
- 0x123452B7 (lui x5,0x12345) -> imm=0x12345000, fmt=4.
- 0x001000EF (jal x1,2048) -> imm=0x00000800, fmt=5.
- 0x002081B3 (add) -> imm=0, fmt=0, illegal=0.
- 0x0000007F -> imm=0, fmt=7, illegal=1.
REQ-030 SHALL cover backpressure:
- Stimulus: stream of 4 instructions with in_valid=1; hold out_ready=0 for 3 cycles, then 1.
- Skid build: in_ready falls after 2 accepted inputs.
- No-skid build: in_ready falls after 1 accepted input.
- Both builds: all 4 results emerge in order and stay stable while stalled.
REQ-031 SHALL cover full throughput: back-to-back input with out_ready=1 -> one result per cycle, with the first result 1 cycle after the first accept.
REQ-032 SHALL cover reset mid-operation: rst=1 for 1 cycle while both entries are full -> next cycle out_valid=0, imm=0, and the buffered results are never emitted.
REQ-033 SHALL cover XLEN=64: 0xFFF00093 -> imm=0xFFFFFFFFFFFFFFFF; 0x123452B7 -> 0x0000000012345000.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - RV32I immediate generator behind a valid/ready output stage.
// Define IMM_GEN_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  logic [2:0]      dec_fmt;
  logic [XLEN-1:0] dec_imm;
  logic            dec_ill;

  always_comb begin
    dec_fmt = FMT_ILL;
    unique case (inst[6:0])
      7'b0000011, 7'b0010011, 7'b1100111,
      7'b0001111, 7'b1110011: dec_fmt = FMT_I;
      7'b0100011:             dec_fmt = FMT_S;
      7'b1100011:             dec_fmt = FMT_B;
      7'b0110111, 7'b0010111: dec_fmt = FMT_U;
      7'b1101111:             dec_fmt = FMT_J;
      7'b0110011:             dec_fmt = FMT_R;
      default:                dec_fmt = FMT_ILL;
    endcase
  end

  // Every replication count stays >= 1 for XLEN of 32 or 64.
  always_comb begin
    dec_imm = '0;
    dec_ill = 1'b0;
    case (dec_fmt)
      FMT_I:   dec_imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
      FMT_S:   dec_imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   dec_imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7],
                          inst[30:25], inst[11:8], 1'b0};
      FMT_U:   dec_imm = {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0};
      FMT_J:   dec_imm = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12],
                          inst[20], inst[30:21], 1'b0};
      FMT_ILL: dec_ill = 1'b1;
      default: dec_imm = '0;
    endcase
  end

  logic            out_valid_q;
  logic [XLEN-1:0] imm_q;
  logic [2:0]      fmt_q;
  logic            ill_q;
  logic            in_fire;
  logic            out_free;

  assign in_fire  = in_valid && in_ready;
  assign out_free = !out_valid_q || out_ready;

  // Gated so a consumer never sees a transfer in the reset cycle.
  assign out_valid = out_valid_q && !rst;
  assign imm       = imm_q;
  assign fmt       = fmt_q;
  assign illegal   = ill_q;

`ifdef IMM_GEN_SKID_EN

  logic            skid_valid_q;
  logic [XLEN-1:0] skid_imm_q;
  logic [2:0]      skid_fmt_q;
  logic            skid_ill_q;

  // Depends only on state and rst, never on out_ready.
  assign in_ready = rst || !skid_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      imm_q        <= '0;
      fmt_q        <= FMT_R;
      ill_q        <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= FMT_R;
      skid_ill_q   <= 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        imm_q        <= skid_imm_q;
        fmt_q        <= skid_fmt_q;
        ill_q        <= skid_ill_q;
        skid_valid_q <= 1'b0;
      end else if (in_fire) begin
        out_valid_q <= 1'b1;
        imm_q       <= dec_imm;
        fmt_q       <= dec_fmt;
        ill_q       <= dec_ill;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_q <= 1'b1;
      skid_imm_q   <= dec_imm;
      skid_fmt_q   <= dec_fmt;
      skid_ill_q   <= dec_ill;
    end
  end

`else

  assign in_ready = out_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      imm_q       <= '0;
      fmt_q       <= FMT_R;
      ill_q       <= 1'b0;
    end else if (in_fire) begin
      out_valid_q <= 1'b1;
      imm_q       <= dec_imm;
      fmt_q       <= dec_fmt;
      ill_q       <= dec_ill;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - randomized scoreboard bench for imm_gen_pipe (XLEN 32 and 64 side by side).
module tb_imm_gen_pipe;

`ifdef IMM_GEN_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] inst;

  logic        in_ready, out_valid, illegal;
  logic [31:0] imm;
  logic [2:0]  fmt;
  logic        in_ready64, out_valid64, illegal64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .out_valid(out_valid), .out_ready(out_ready), .imm(imm), .fmt(fmt), .illegal(illegal)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64), .inst(inst),
    .out_valid(out_valid64), .out_ready(out_ready), .imm(imm64), .fmt(fmt64), .illegal(illegal64)
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } res_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Field value as unsigned, then subtract 2^n when the sign bit is set.
  function automatic res_t ref_decode(input logic [31:0] w);
    res_t r;
    longint v;
    int n;
    v = 0;
    n = 0;
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: r.fmt = 3'd1;
      7'h23:                             r.fmt = 3'd2;
      7'h63:                             r.fmt = 3'd3;
      7'h37, 7'h17:                      r.fmt = 3'd4;
      7'h6F:                             r.fmt = 3'd5;
      7'h33:                             r.fmt = 3'd0;
      default:                           r.fmt = 3'd7;
    endcase
    case (r.fmt)
      3'd1: begin v = longint'(w[31:20]); n = 12; end
      3'd2: begin v = longint'({w[31:25], w[11:7]}); n = 12; end
      3'd3: begin v = longint'({w[31], w[7], w[30:25], w[11:8], 1'b0}); n = 13; end
      3'd4: begin v = longint'({w[31:12], 12'b0}); n = 32; end
      3'd5: begin v = longint'({w[31], w[19:12], w[20], w[30:21], 1'b0}); n = 21; end
      default: begin v = 0; n = 0; end
    endcase
    if (n != 0 && w[31]) v = v - (longint'(1) << n);
    r.imm = 64'(v);
    r.ill = (r.fmt == 3'd7);
    return r;
  endfunction

  res_t q[$];
  bit   in_fire_s  = 1'b0;
  bit   out_fire_s = 1'b0;
  bit   after_rst  = 1'b0;

  always @(negedge clk) begin
    bit ev, er;
    ev = (q.size() > 0) && !rst;
    er = SKID ? (rst || q.size() < 2) : (q.size() == 0 || out_ready);
    chk("in_ready", 64'(in_ready), 64'(er));
    chk("in_ready64", 64'(in_ready64), 64'(er));
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("out_valid64", 64'(out_valid64), 64'(ev));
    if (ev) begin
      chk("imm", 64'(imm), 64'(q[0].imm[31:0]));
      chk("fmt", 64'(fmt), 64'(q[0].fmt));
      chk("illegal", 64'(illegal), 64'(q[0].ill));
      chk("imm64", imm64, q[0].imm);
      chk("fmt64", 64'(fmt64), 64'(q[0].fmt));
    end else if (after_rst) begin
      chk("rst_imm", 64'(imm), 64'd0);
      chk("rst_imm64", imm64, 64'd0);
      chk("rst_fmt", 64'(fmt), 64'd0);
      chk("rst_illegal", 64'(illegal), 64'd0);
    end
    in_fire_s  = in_valid && in_ready && !rst;
    out_fire_s = out_valid && out_ready;
  end

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (out_fire_s && q.size() > 0) void'(q.pop_front());
      if (in_fire_s) q.push_back(ref_decode(inst));
    end
    after_rst = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [11];
    logic [31:0] w;
    ops = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    w = $urandom;
    if ($urandom_range(0, 9) < 8) w[6:0] = ops[$urandom_range(0, 10)];
    return w;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dir [7];
    logic [31:0] bp [4];
    res_t r;
    int accepts, outs, idx, k;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; inst = 32'h0;

    r = ref_decode(32'hFFF00093); chk("lit_addi", r.imm[31:0], 32'hFFFFFFFF); chk("lit_addi_fmt", 64'(r.fmt), 64'd1);
    r = ref_decode(32'hFE112E23); chk("lit_sw", r.imm[31:0], 32'hFFFFFFFC); chk("lit_sw_fmt", 64'(r.fmt), 64'd2);
    r = ref_decode(32'hFE000CE3); chk("lit_beq", r.imm[31:0], 32'hFFFFFFF8); chk("lit_beq_fmt", 64'(r.fmt), 64'd3);
    r = ref_decode(32'h123452B7); chk("lit_lui", r.imm[31:0], 32'h12345000); chk("lit_lui_fmt", 64'(r.fmt), 64'd4);
    r = ref_decode(32'h001000EF); chk("lit_jal", r.imm[31:0], 32'h00000800); chk("lit_jal_fmt", 64'(r.fmt), 64'd5);
    r = ref_decode(32'h002081B3); chk("lit_add", r.imm, 64'd0); chk("lit_add_fmt", 64'(r.fmt), 64'd0);
    r = ref_decode(32'h0000007F); chk("lit_ill", r.imm, 64'd0); chk("lit_ill_flag", 64'(r.ill), 64'd1);
    r = ref_decode(32'hFFF00093); chk("lit_addi64", r.imm, 64'hFFFFFFFFFFFFFFFF);
    r = ref_decode(32'h123452B7); chk("lit_lui64", r.imm, 64'h0000000012345000);

    repeat (2) tick();
    rst = 1'b0;

    dir = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123452B7,
            32'h001000EF, 32'h002081B3, 32'h0000007F};
    for (int i = 0; i < 7; i++) begin
      inst = dir[i]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; inst = $urandom;
      tick();
      tick();
    end

    bp = '{32'hFFF00093, 32'hFE112E23, 32'h123452B7, 32'h001000EF};
    out_ready = 1'b0; accepts = 0; idx = 0;
    inst = bp[0]; in_valid = 1'b1;
    repeat (3) begin
      tick();
      if (in_fire_s) begin accepts++; idx++; end
      if (idx < 4) inst = bp[idx]; else in_valid = 1'b0;
    end
    chk("bp_accepts_stalled", 64'(accepts), SKID ? 64'd2 : 64'd1);
    out_ready = 1'b1;
    k = 0;
    while ((idx < 4 || q.size() > 0) && k < 20) begin
      tick();
      if (in_fire_s) begin accepts++; idx++; end
      if (idx < 4) inst = bp[idx]; else in_valid = 1'b0;
      k++;
    end
    chk("bp_total_accepts", 64'(accepts), 64'd4);
    chk("bp_drained", 64'(q.size()), 64'd0);

    accepts = 0; outs = 0;
    for (int i = 0; i < 9; i++) begin
      in_valid = (i < 8);
      inst = rand_inst();
      tick();
      if (in_fire_s) accepts++;
      if (out_fire_s) outs++;
    end
    chk("tput_accepts", 64'(accepts), 64'd8);
    chk("tput_outputs", 64'(outs), 64'd8);
    in_valid = 1'b0;
    repeat (2) tick();

    out_ready = 1'b0; in_valid = 1'b1;
    repeat (3) begin inst = rand_inst(); tick(); end
    rst = 1'b1; inst = rand_inst();
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    outs = 0;
    repeat (4) begin tick(); if (out_fire_s) outs++; end
    chk("rst_no_emit", 64'(outs), 64'd0);

    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 9) < 7);
      inst      = rand_inst();
      tick();
    end

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    k = 0;
    while (q.size() > 0 && k < 10) begin tick(); k++; end
    tick();
    chk("final_drain", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
